// File: rtl/ccr_pkg.sv
// rtl/ccr_pkg.sv - shared opcodes, branch codes, flag indices and stack FSM encoding
package ccr_pkg;

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_NOT  = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_LD   = 4'b0011;
    localparam logic [3:0] OP_SUB  = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_OR   = 4'b0110;
    localparam logic [3:0] OP_INC  = 4'b0111;
    localparam logic [3:0] OP_DEC  = 4'b1000;
    localparam logic [3:0] OP_SETC = 4'b1001;
    localparam logic [3:0] OP_CLRC = 4'b1010;
    localparam logic [3:0] OP_SHL  = 4'b1011;
    localparam logic [3:0] OP_SHR  = 4'b1100;

    localparam logic [1:0] BR_NONE = 2'b00;
    localparam logic [1:0] BR_JZ   = 2'b01;
    localparam logic [1:0] BR_JN   = 2'b10;
    localparam logic [1:0] BR_JC   = 2'b11;

    localparam int F_Z = 0;
    localparam int F_C = 1;
    localparam int F_N = 2;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'b00,
        ST_PARTIAL = 2'b01,
        ST_FULL    = 2'b10
    } stk_state_e;

endpackage

// File: rtl/ccr_shadow_stack.sv
// rtl/ccr_shadow_stack.sv - interrupt flag shadow stack with swap path; sticky error under CCR_STK_ERR_EN
module ccr_shadow_stack
    import ccr_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int DW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] push_data,
    input  logic [DW-1:0] swap_data,
    output logic [DW-1:0] top,
    output logic          restore,
    output logic [3:0]    depth,
    output logic          err
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [3:0]    depth_q, depth_d;
    stk_state_e    state_q, state_d;
    logic          wr_en;
    logic [3:0]    wr_idx;
    logic [DW-1:0] wr_data;

    // Read the top-of-stack entry (slot depth-1); zero when empty.
    always_comb begin
        top = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (4'(i) + 4'd1 == depth_q) top = mem_q[i];
        end
    end

    // Decode push/pop/swap against the FSM state; full pushes and empty pops are dropped.
    always_comb begin
        depth_d = depth_q;
        wr_en   = 1'b0;
        wr_idx  = depth_q;
        wr_data = push_data;
        restore = 1'b0;
        if (push && pop && state_q != ST_EMPTY) begin
            restore = 1'b1;
            wr_en   = 1'b1;
            wr_idx  = depth_q - 4'd1;
            wr_data = swap_data;
        end else if (push) begin
            if (state_q != ST_FULL) begin
                wr_en   = 1'b1;
                depth_d = depth_q + 4'd1;
            end
        end else if (pop) begin
            if (state_q != ST_EMPTY) begin
                restore = 1'b1;
                depth_d = depth_q - 4'd1;
            end
        end
        if (depth_d == 4'd0)             state_d = ST_EMPTY;
        else if (depth_d == 4'(DEPTH))   state_d = ST_FULL;
        else                             state_d = ST_PARTIAL;
    end

    // State, occupancy and entry registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            depth_q <= 4'd0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q <= state_d;
            depth_q <= depth_d;
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_en && 4'(i) == wr_idx) mem_q[i] <= wr_data;
            end
        end
    end

    assign depth = depth_q;

`ifdef CCR_STK_ERR_EN
    logic err_q, err_d;

    // Sticky flag: overflow is a lone push when full, underflow a lone pop when empty.
    always_comb begin
        err_d = err_q;
        if (push && !pop && state_q == ST_FULL)  err_d = 1'b1;
        if (pop && !push && state_q == ST_EMPTY) err_d = 1'b1;
    end

    // Error register, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: rtl/ccr_ctrl.sv
// rtl/ccr_ctrl.sv - EX-stage condition-code register, flag mask, branch evaluation; stk_err via CCR_STK_ERR_EN
module ccr_ctrl
    import ccr_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int DW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ex_valid,
    input  logic          stall,
    input  logic          flush,
    input  logic [3:0]    alu_op,
    input  logic [DW-1:0] alu_flag,
    input  logic [1:0]    br_type,
    input  logic          int_save,
    input  logic          rti_restore,
    output logic [DW-1:0] ccr,
    output logic          br_taken,
    output logic [3:0]    stk_depth,
    output logic          stk_err
);

    logic [DW-1:0] ccr_q, ccr_d, ccr_upd, stk_top;
    logic          upd, br_hit, stk_restore;

    assign upd = ex_valid & ~stall & ~flush;

    // Branch condition tested against the registered flags only.
    always_comb begin
        br_hit = 1'b0;
        case (br_type)
            BR_JZ:   br_hit = ccr_q[F_Z];
            BR_JN:   br_hit = ccr_q[F_N];
            BR_JC:   br_hit = ccr_q[F_C];
            default: br_hit = 1'b0;
        endcase
    end

    assign br_taken = upd & br_hit & ~rst;

    // Per-opcode flag mask, then clear the flag a taken branch consumed.
    always_comb begin
        ccr_upd = ccr_q;
        if (upd) begin
            case (alu_op)
                OP_NOT, OP_AND, OP_OR: begin
                    ccr_upd[F_N] = alu_flag[F_N];
                    ccr_upd[F_Z] = alu_flag[F_Z];
                end
                OP_ADD, OP_SUB, OP_INC, OP_DEC, OP_SHL, OP_SHR:
                    ccr_upd = alu_flag;
                OP_SETC: ccr_upd[F_C] = 1'b1;
                OP_CLRC: ccr_upd[F_C] = 1'b0;
                default: ;
            endcase
        end
        if (br_taken) begin
            case (br_type)
                BR_JZ:   ccr_upd[F_Z] = 1'b0;
                BR_JN:   ccr_upd[F_N] = 1'b0;
                BR_JC:   ccr_upd[F_C] = 1'b0;
                default: ;
            endcase
        end
    end

    // A successful pop or swap overrides this cycle's flag update.
    always_comb begin
        ccr_d = stk_restore ? stk_top : ccr_upd;
    end

    // Condition-code register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ccr_q <= '0;
        else     ccr_q <= ccr_d;
    end

    ccr_shadow_stack #(
        .DEPTH (DEPTH),
        .DW    (DW)
    ) u_stack (
        .clk       (clk),
        .rst       (rst),
        .push      (int_save),
        .pop       (rti_restore),
        .push_data (ccr_upd),
        .swap_data (ccr_q),
        .top       (stk_top),
        .restore   (stk_restore),
        .depth     (stk_depth),
        .err       (stk_err)
    );

    assign ccr = ccr_q;

endmodule

// File: doc/ccr_ctrl.md
Name: ccr_ctrl

Overview:
- Execute-stage condition-code register (CCR) controller for the pipelined processor's ALU.
- Owns the registered {N,C,Z} flags and replaces the ALU's self-referencing flag holds with a clocked register.
- Applies a per-opcode flag-update mask, evaluates conditional branches (JZ/JN/JC) and clears the tested flag when a branch is taken.
- Saves and restores flags on interrupt entry and RTI through a small shadow stack.

Parameters:
- DEPTH, 2, shadow-stack entries (nesting depth of interrupts); legal range 1..8.
- DW, 3, flag width {N,C,Z}; fixed, not to be overridden.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high. Clears all state.
- ex_valid  in  1  EX-stage instruction is valid.
- stall  in  1  EX stage held; CCR and stack hold.
- flush  in  1  EX instruction squashed; no flag update, no branch.
- alu_op  in  4  ALU control code of the EX instruction.
- alu_flag  in  3  ALU result flags {N,C,Z} for the EX instruction.
- br_type  in  2  00 none, 01 JZ, 10 JN, 11 JC.
- int_save  in  1  push CCR onto the shadow stack (interrupt entry).
- rti_restore  in  1  pop the shadow stack into the CCR.
- ccr  out  3  registered flags {N,C,Z}.
- br_taken  out  1  conditional branch taken (combinational).
- stk_depth  out  4  current shadow-stack occupancy.
- stk_err  out  1  sticky stack error (see Optional Feature).

Behaviour:
- Reset values: ccr=000, stk_depth=0, stk_err=0, all stack entries=000. br_taken is 0 whenever rst is high.
- Update qualifier: upd = ex_valid & ~stall & ~flush.
- br_taken = upd & (JZ&Z | JN&N | JC&C). It is evaluated against the registered ccr only; there is no same-cycle forwarding.
- Flag mask per alu_op (applied when upd):
  - 0000 NOP, 0011 LDM/LDD/STD, 1101-1111: no change.
  - 0001 NOT, 0101 AND, 0110 OR: load N,Z; hold C.
  - 0010 ADD, 0100 SUB, 0111 INC, 1000 DEC, 1011 SHL, 1100 SHR: load N,C,Z.
  - 1001 SETC: C=1, N and Z hold.
  - 1010 CLRC: C=0, N and Z hold.
- Taken branch: the tested flag is cleared next cycle. This clear overrides the mask result for that bit; the other bits still follow the mask.
- Flag latency: 1 cycle. An instruction at EX in cycle t sees ccr written by the instruction at EX in cycle t-1.
- Stack and CCR priority each cycle: rst > stack op > flag update. Stack ops are not gated by stall or flush.
- int_save only: push ccr_next (the post-update value of this cycle) and increment depth. ccr itself still updates normally.
- rti_restore only: ccr <= top entry and decrement depth. The flag update for that cycle is discarded.
- Both asserted: swap. ccr <= top, top <= current ccr, depth unchanged.
- Both asserted with depth=0: treated as a push only.
- Push with depth=DEPTH: dropped, ccr unaffected, error event.
- Pop with depth=0: ccr keeps normal update behaviour, depth stays 0, error event.
- Stack controller FSM:
  - States EMPTY (depth=0), PARTIAL, FULL (depth=DEPTH).
  - Transitions follow push/pop/swap; DEPTH=1 skips PARTIAL.
  - stk_depth always reflects the registered count.

Optional Feature:
- Macro: CCR_STK_ERR_EN.
- Defined: stk_err is set on any overflow or underflow event and stays set until rst.
- Not defined: stk_err is tied to 0 and the error logic is absent. Overflow and underflow behaviour is otherwise identical (dropped push, ignored pop).

Decomposition:
- Package ccr_pkg holds:
  - ALU opcode localparams (OP_NOP, OP_NOT, OP_ADD, OP_LD, OP_SUB, OP_AND, OP_OR, OP_INC, OP_DEC, OP_SETC, OP_CLRC, OP_SHL, OP_SHR).
  - Branch codes BR_NONE/BR_JZ/BR_JN/BR_JC.
  - Flag indices F_Z=0, F_C=1, F_N=2.
  - Stack FSM state encoding.
- Sub-module ccr_shadow_stack contains:
  - DEPTH x 3 register array, depth counter, FSM, swap path and error detection.
- ccr_ctrl keeps the mask, branch logic and CCR register.

Test Plan:
- Reset mid-run with ccr=111 and depth=1 -> ccr=000, depth=0, stk_err=0 immediately (asynchronous).
- ADD with alu_flag=011 -> ccr=011 next cycle. Then AND with alu_flag=100 -> ccr=110 (C held). Then LDD with alu_flag=001 -> ccr stays 110.
- ccr=001, br_type=JZ, upd -> br_taken=1 and ccr=000 next cycle. Same with flush=1 -> br_taken=0, ccr stays 001.
- ccr=010, SETC issued together with stall=1 -> no change. Then CLRC unstalled -> ccr=000.
- DEPTH=2: push 101, push 011, push 111 -> depth=2 and third push dropped, stk_err=1 with macro (0 without). Then pop, pop -> ccr=011 then 101. A further pop -> ccr unchanged, depth=0.
- depth=1 top=100, ccr=001, int_save and rti_restore together -> ccr=100, top=001, depth=1.
